// File: rtl/vector_ls_sequencer.sv
// -----------------------------------------------------------------------------
// vector_ls_sequencer
//
// Purpose:
//   Turns one vector load/store instruction (VLW, VSW, VLWO, VSWO) into a
//   series of scalar accesses on the single data-memory port. Lanes are
//   visited in ascending index order, and disabled lanes are skipped. While
//   accesses are in flight the pipeline is stalled. When the instruction
//   completes, the block emits a one-cycle done pulse. For loads it also
//   returns the gathered data with per-lane vector-register write enables.
//
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   vls_start    instruction present in execute (sampled only in IDLE)
//   vls_store    1 = store (VSW/VSWO), 0 = load (VLW/VLWO)
//   vls_mask     per-lane enable
//   vls_addr     per-lane effective address, lane i at [32i+31:32i]
//   vls_wdata    per-lane store data, lane i at [32i+31:32i]
//   vls_busy     pipeline stall request
//   vls_done     one-cycle completion pulse
//   vls_rdata    gathered load data, lane i at [32i+31:32i]
//   vls_wen      per-lane vreg write enable, valid only with vls_done
//   dmem_ren     memory read request
//   dmem_wen     memory write request
//   dmem_addr    word-aligned memory address
//   dmem_store   memory write data
//   dmem_hit     access completes this cycle
//   dmem_load    memory read data, valid with dmem_hit on reads
// -----------------------------------------------------------------------------
module vector_ls_sequencer #(
    parameter int unsigned THREADS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  vls_start,
    input  logic                  vls_store,
    input  logic [THREADS-1:0]    vls_mask,
    input  logic [THREADS*32-1:0] vls_addr,
    input  logic [THREADS*32-1:0] vls_wdata,
    output logic                  vls_busy,
    output logic                  vls_done,
    output logic [THREADS*32-1:0] vls_rdata,
    output logic [THREADS-1:0]    vls_wen,
    output logic                  dmem_ren,
    output logic                  dmem_wen,
    output logic [31:0]           dmem_addr,
    output logic [31:0]           dmem_store,
    input  logic                  dmem_hit,
    input  logic [31:0]           dmem_load
);

    localparam int unsigned PtrW = (THREADS > 1) ? $clog2(THREADS) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Architectural state
    state_e            r_state;
    logic              r_store;
    logic [THREADS-1:0] r_mask;
    logic [PtrW-1:0]   r_ptr;
    // Only the word address is kept; byte offset bits are never driven out.
    logic [29:0]       r_addr  [THREADS];
    logic [31:0]       r_wdata [THREADS];
    logic [31:0]       r_rdata [THREADS];

    // Combinational helpers
    state_e            w_state_next;
    logic [PtrW-1:0]   w_first_idx;
    logic              w_next_found;
    logic [PtrW-1:0]   w_next_idx;
    logic [29:0]       w_cur_addr;
    logic [31:0]       w_cur_wdata;
    logic [THREADS-1:0] w_unused_addr_lsbs;

    // Byte-offset bits of every lane address are ignored by design.
    always_comb begin
        w_unused_addr_lsbs = '0;
        for (int i = 0; i < int'(THREADS); i++) begin
            w_unused_addr_lsbs[i] = ^vls_addr[32*i +: 2];
        end
    end

    // Lowest enabled lane of the incoming mask. Scanning downward lets the
    // lowest set bit take the last assignment.
    always_comb begin
        w_first_idx = '0;
        for (int i = int'(THREADS) - 1; i >= 0; i--) begin
            if (vls_mask[i]) begin
                w_first_idx = PtrW'(i);
            end
        end
    end

    // Next enabled lane strictly above the current pointer, from the snapshot.
    always_comb begin
        w_next_found = 1'b0;
        w_next_idx   = '0;
        for (int i = int'(THREADS) - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_ptr))) begin
                w_next_found = 1'b1;
                w_next_idx   = PtrW'(i);
            end
        end
    end

    assign w_cur_addr  = r_addr[r_ptr];
    assign w_cur_wdata = r_wdata[r_ptr];

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (vls_start) begin
                    w_state_next = (|vls_mask) ? StAccess : StDone;
                end
            end
            StAccess: begin
                if (dmem_hit && !w_next_found) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                // start is not sampled here; the pipeline is still advancing
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so a reset edge clears
    // every request in the following cycle.
    always_comb begin
        vls_busy   = 1'b0;
        vls_done   = 1'b0;
        vls_wen    = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_store = '0;
        unique case (r_state)
            StAccess: begin
                vls_busy   = 1'b1;
                dmem_ren   = ~r_store;
                dmem_wen   = r_store;
                dmem_addr  = {w_cur_addr, 2'b00};
                dmem_store = r_store ? w_cur_wdata : 32'h0;
            end
            StDone: begin
                vls_done = 1'b1;
                vls_wen  = r_store ? '0 : r_mask;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        vls_rdata = '0;
        for (int i = 0; i < int'(THREADS); i++) begin
            vls_rdata[32*i +: 32] = r_rdata[i];
        end
    end

    // State register and datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_store <= 1'b0;
            r_mask  <= '0;
            r_ptr   <= '0;
            for (int i = 0; i < int'(THREADS); i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_rdata[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (vls_start) begin
                        // Snapshot; inputs are not looked at again until IDLE.
                        r_store <= vls_store;
                        r_mask  <= vls_mask;
                        r_ptr   <= w_first_idx;
                        for (int i = 0; i < int'(THREADS); i++) begin
                            r_addr[i]  <= vls_addr[32*i+2 +: 30];
                            r_wdata[i] <= vls_wdata[32*i +: 32];
                        end
                    end
                end
                StAccess: begin
                    if (dmem_hit) begin
                        if (!r_store) begin
                            r_rdata[r_ptr] <= dmem_load;
                        end
                        if (w_next_found) begin
                            r_ptr <= w_next_idx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_ls_sequencer.sv
module tb_vector_ls_sequencer;

    logic         CLK;
    logic         RST;
    logic         vls_start;
    logic         vls_store;
    logic [3:0]   vls_mask;
    logic [127:0] vls_addr;
    logic [127:0] vls_wdata;
    logic         vls_busy;
    logic         vls_done;
    logic [127:0] vls_rdata;
    logic [3:0]   vls_wen;
    logic         dmem_ren;
    logic         dmem_wen;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_store;
    logic         dmem_hit;
    logic [31:0]  dmem_load;

    int n_assert;
    int n_fail;

    vector_ls_sequencer #(
        .THREADS(4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .vls_start (vls_start),
        .vls_store (vls_store),
        .vls_mask  (vls_mask),
        .vls_addr  (vls_addr),
        .vls_wdata (vls_wdata),
        .vls_busy  (vls_busy),
        .vls_done  (vls_done),
        .vls_rdata (vls_rdata),
        .vls_wen   (vls_wen),
        .dmem_ren  (dmem_ren),
        .dmem_wen  (dmem_wen),
        .dmem_addr (dmem_addr),
        .dmem_store(dmem_store),
        .dmem_hit  (dmem_hit),
        .dmem_load (dmem_load)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Checks the idle-style outputs: no requests, no busy.
    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"}, 128'(vls_busy), 128'd0);
        chk({tag, ".ren"},  128'(dmem_ren), 128'd0);
        chk({tag, ".wen"},  128'(dmem_wen), 128'd0);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        RST       = 1'b1;
        vls_start = 1'b0;
        vls_store = 1'b0;
        vls_mask  = '0;
        vls_addr  = '0;
        vls_wdata = '0;
        dmem_hit  = 1'b0;
        dmem_load = '0;
        tick();
        tick();
        RST = 1'b0;

        // Reset state
        chk_quiet("rst");
        chk("rst.done",  128'(vls_done),   128'd0);
        chk("rst.vwen",  128'(vls_wen),    128'd0);
        chk("rst.addr",  128'(dmem_addr),  128'd0);
        chk("rst.store", 128'(dmem_store), 128'd0);
        chk("rst.rdata", vls_rdata,        128'd0);

        // Load all lanes, zero wait
        vls_start = 1'b1;
        vls_store = 1'b0;
        vls_mask  = 4'b1111;
        vls_addr  = {32'h10C, 32'h108, 32'h104, 32'h100};
        tick();
        vls_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ld4.busy", 128'(vls_busy),  128'd1);
            chk("ld4.ren",  128'(dmem_ren),  128'd1);
            chk("ld4.wen",  128'(dmem_wen),  128'd0);
            chk("ld4.addr", 128'(dmem_addr), 128'(32'h100 + 32'(4 * i)));
            chk("ld4.done", 128'(vls_done),  128'd0);
            dmem_hit  = 1'b1;
            dmem_load = 32'hA0 + 32'(i);
            tick();
        end
        dmem_hit = 1'b0;
        chk("ld4.done5",  128'(vls_done), 128'd1);
        chk_quiet("ld4.c5");
        chk("ld4.vwen",   128'(vls_wen),  128'b1111);
        chk("ld4.rdata",  vls_rdata,      {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        tick();
        chk("ld4.done6",  128'(vls_done), 128'd0);

        // Masked store, two wait cycles before each hit
        vls_start = 1'b1;
        vls_store = 1'b1;
        vls_mask  = 4'b0101;
        vls_addr  = {32'hDEAD0000, 32'h208, 32'hBEEF0000, 32'h200};
        vls_wdata = {32'h44, 32'h33, 32'h22, 32'h11};
        tick();
        vls_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("st.wen",   128'(dmem_wen),   128'd1);
            chk("st.ren",   128'(dmem_ren),   128'd0);
            chk("st.busy",  128'(vls_busy),   128'd1);
            chk("st.addr",  128'(dmem_addr),  (c <= 3) ? 128'h200 : 128'h208);
            chk("st.data",  128'(dmem_store), (c <= 3) ? 128'h11 : 128'h33);
            dmem_hit = (c == 3 || c == 6);
            tick();
        end
        dmem_hit = 1'b0;
        chk("st.done7",  128'(vls_done), 128'd1);
        chk("st.vwen",   128'(vls_wen),  128'd0);
        chk_quiet("st.c7");
        chk("st.rdata",  vls_rdata,      {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        tick();

        // Empty mask; a stray hit during DONE must not touch rdata
        vls_start = 1'b1;
        vls_store = 1'b0;
        vls_mask  = 4'b0000;
        tick();
        vls_start = 1'b0;
        chk("empty.done", 128'(vls_done), 128'd1);
        chk("empty.vwen", 128'(vls_wen),  128'd0);
        chk_quiet("empty.c1");
        dmem_hit  = 1'b1;
        dmem_load = 32'hFFFF_FFFF;
        tick();
        dmem_hit = 1'b0;
        chk("empty.done2", 128'(vls_done), 128'd0);
        chk("empty.rdata", vls_rdata,      {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Unaligned address, single lane load
        vls_start = 1'b1;
        vls_store = 1'b0;
        vls_mask  = 4'b0001;
        vls_addr  = {32'h0, 32'h0, 32'h0, 32'h103};
        tick();
        vls_start = 1'b0;
        chk("ua.addr", 128'(dmem_addr), 128'h100);
        chk("ua.ren",  128'(dmem_ren),  128'd1);
        dmem_hit  = 1'b1;
        dmem_load = 32'h5555AAAA;
        tick();
        dmem_hit = 1'b0;
        chk("ua.done",  128'(vls_done), 128'd1);
        chk("ua.vwen",  128'(vls_wen),  128'b0001);
        chk("ua.rdata", vls_rdata,      {32'hA3, 32'hA2, 32'hA1, 32'h5555AAAA});
        tick();

        // Reset while lane 2 awaits its hit
        vls_start = 1'b1;
        vls_store = 1'b0;
        vls_mask  = 4'b1111;
        vls_addr  = {32'h30C, 32'h308, 32'h304, 32'h300};
        tick();
        vls_start = 1'b0;
        dmem_hit  = 1'b1;
        dmem_load = 32'hB0;
        tick();
        dmem_load = 32'hB1;
        tick();
        dmem_hit = 1'b0;
        chk("rmid.addr", 128'(dmem_addr), 128'h308);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_quiet("rmid.c1");
        chk("rmid.done",  128'(vls_done), 128'd0);
        chk("rmid.rdata", vls_rdata,      128'd0);
        tick();
        chk("rmid.done2", 128'(vls_done), 128'd0);
        chk("rmid.busy2", 128'(vls_busy), 128'd0);

        // Restart after reset begins at lane 0
        vls_start = 1'b1;
        vls_mask  = 4'b0011;
        vls_addr  = {32'h0, 32'h0, 32'h504, 32'h500};
        tick();
        vls_start = 1'b0;
        chk("rs.addr0", 128'(dmem_addr), 128'h500);
        dmem_hit  = 1'b1;
        dmem_load = 32'hD0;
        tick();
        chk("rs.addr1", 128'(dmem_addr), 128'h504);
        dmem_load = 32'hD1;
        tick();
        dmem_hit = 1'b0;
        chk("rs.done",  128'(vls_done), 128'd1);
        chk("rs.rdata", vls_rdata,      {32'h0, 32'h0, 32'hD1, 32'hD0});
        tick();

        // Snapshot: inputs change during ACCESS; start held through DONE
        vls_start = 1'b1;
        vls_store = 1'b0;
        vls_mask  = 4'b0011;
        vls_addr  = {32'h0, 32'h0, 32'h404, 32'h400};
        tick();
        vls_mask  = 4'b1100;
        vls_addr  = {4{32'h900}};
        vls_store = 1'b1;
        chk("snap.addr0", 128'(dmem_addr), 128'h400);
        chk("snap.ren0",  128'(dmem_ren),  128'd1);
        dmem_hit  = 1'b1;
        dmem_load = 32'hC0;
        tick();
        chk("snap.addr1", 128'(dmem_addr), 128'h404);
        chk("snap.ren1",  128'(dmem_ren),  128'd1);
        dmem_load = 32'hC1;
        tick();
        dmem_hit = 1'b0;
        chk("snap.done",  128'(vls_done), 128'd1);
        chk("snap.vwen",  128'(vls_wen),  128'b0011);
        chk("snap.rdata", vls_rdata,      {32'h0, 32'h0, 32'hC1, 32'hC0});
        tick();
        vls_start = 1'b0;
        chk_quiet("snap.c4");
        chk("snap.done4", 128'(vls_done), 128'd0);
        tick();
        chk_quiet("snap.c5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
